sdram_req_arbiter: RTL and testbench

- Shares one sdram_controller between NUM_REQ client ports using round-robin arbitration.
- Converts each granted client request into a single-cycle read_req/write_req pulse to the controller, then waits for the controller's data_valid completion before returning done to that client.
- Schedules periodic refresh, which takes priority over client traffic.
- Sits directly above sdram_controller; clients are the DMA and CPU bridge ports.

---
 rtl/sdram_arb_pkg.sv | 14 +
 rtl/sdram_req_arbiter_if.sv | 23 ++
 rtl/rr_priority_pick.sv | 24 ++
 rtl/sdram_req_arbiter.sv | 86 ++++++++
 tb/tb_sdram_req_arbiter.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared state encoding and width helpers for the SDRAM request arbiter
package sdram_arb_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, REFRESH} state_t;
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   localparam int NUM_REQ_DEF = 4;
   localparam int TIMEOUT_DEF = 16;
   localparam int REFRESH_INTERVAL_DEF = 64;
   localparam int REFRESH_CYCLES_DEF = 4;
   localparam int OWNER_W = idx_w(NUM_REQ_DEF);
   localparam int TIMER_W = idx_w(TIMEOUT_DEF);
   localparam int RCNT_W = idx_w(REFRESH_INTERVAL_DEF);
endpackage

// File: rtl/sdram_req_arbiter_if.sv
// sdram_req_arbiter_if: client request bundle plus sdram_controller command/completion lines
interface sdram_req_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] req_we;
   logic [NUM_REQ-1:0] grant;
   logic [NUM_REQ-1:0] done;
   logic err;
   logic ctrl_read_req;
   logic ctrl_write_req;
   logic ctrl_refresh_req;
   logic ctrl_data_valid;
   logic refresh_overrun;
   modport master (
      output req, req_we, ctrl_data_valid,
      input grant, done, err, ctrl_read_req, ctrl_write_req, ctrl_refresh_req, refresh_overrun
   );
   modport slave (
      input req, req_we, ctrl_data_valid,
      output grant, done, err, ctrl_read_req, ctrl_write_req, ctrl_refresh_req, refresh_overrun
   );
endinterface

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: first set request at or after ptr, wrapping modulo N
module rr_priority_pick
   import sdram_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]          req,
   input  logic [idx_w(N)-1:0]   ptr,
   output logic                  valid,
   output logic [idx_w(N)-1:0]   winner
);
   localparam int W = idx_w(N);
   logic [W-1:0] idx;
   // scan from the farthest offset down so the nearest-to-ptr request wins
   always_comb begin
      winner = '0;
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         idx = W'((int'(ptr) + i) % N);
         if (req[idx]) winner = idx;
      end
   end
   assign valid = |req;
endmodule

// File: rtl/sdram_req_arbiter.sv
// sdram_req_arbiter: round-robin sharing of one sdram_controller with refresh priority
module sdram_req_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 16,
   parameter int REFRESH_INTERVAL = 64,
   parameter int REFRESH_CYCLES = 4
) (
   input logic clk,
   input logic reset,
   sdram_req_arbiter_if.slave bus
);
   localparam int OW = idx_w(NUM_REQ);
   localparam int TW = idx_w(TIMEOUT > REFRESH_CYCLES ? TIMEOUT : REFRESH_CYCLES);
   localparam int RW = idx_w(REFRESH_INTERVAL);
   state_t state, nxt;
   logic [OW-1:0] owner, ptr, pick;
   logic [TW-1:0] timer;
   logic [RW-1:0] rcnt;
   logic [NUM_REQ-1:0] own_oh, done_q;
   logic we, pick_valid, pending, overrun, err_q, tmo, wrap, wait_end, rfr_end;

   rr_priority_pick #(.N(NUM_REQ)) u_pick (
      .req(bus.req),
      .ptr(ptr),
      .valid(pick_valid),
      .winner(pick)
   );

   assign own_oh = NUM_REQ'(1) << owner;
   assign tmo = timer == TW'(TIMEOUT - 1);
   assign rfr_end = timer == TW'(REFRESH_CYCLES - 1);
   assign wrap = rcnt == RW'(REFRESH_INTERVAL - 1);
   assign wait_end = state == WAIT && (bus.ctrl_data_valid || tmo);

   always_ff @(posedge clk) state <= reset ? IDLE : nxt;

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = pending ? REFRESH : (pick_valid ? ISSUE : IDLE);
         ISSUE:   nxt = WAIT;
         WAIT:    nxt = wait_end ? IDLE : WAIT;
         REFRESH: nxt = rfr_end ? IDLE : REFRESH;
         default: nxt = IDLE;
      endcase
   end

   // timer is shared: WAIT age for timeout, REFRESH dwell count
   always_ff @(posedge clk) begin
      if (reset) begin
         owner <= '0;
         we <= 1'b0;
         ptr <= '0;
         timer <= '0;
         rcnt <= '0;
         pending <= 1'b0;
         overrun <= 1'b0;
         done_q <= '0;
         err_q <= 1'b0;
      end else begin
         rcnt <= wrap ? '0 : rcnt + 1'b1;
         pending <= wrap | (pending & (state != IDLE));
         overrun <= overrun | (wrap & pending);
         timer <= (state == WAIT || state == REFRESH) ? timer + 1'b1 : '0;
         if (state == IDLE && !pending && pick_valid) begin
            owner <= pick;
            we <= bus.req_we[pick];
         end
         if (wait_end) ptr <= (owner == OW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
         done_q <= wait_end ? own_oh : '0;
         err_q <= wait_end & !bus.ctrl_data_valid;
      end
   end

   always_comb begin
      bus.grant = (state == ISSUE || state == WAIT) ? own_oh : '0;
      bus.ctrl_write_req = state == ISSUE && we;
      bus.ctrl_read_req = state == ISSUE && !we;
      bus.ctrl_refresh_req = state == REFRESH && timer == '0;
      bus.done = done_q;
      bus.err = err_q;
      bus.refresh_overrun = overrun;
   end
endmodule

// File: tb/tb_sdram_req_arbiter.sv
// tb_sdram_req_arbiter: directed and random stimulus against a cycle-age reference model
module tb_sdram_req_arbiter;
   localparam int N = 4, TO = 16, RI = 64, RC = 4;
   logic clk = 0, rst = 1;
   always #5 clk = ~clk;

   sdram_req_arbiter_if #(.NUM_REQ(N)) ifa ();
   sdram_req_arbiter_if #(.NUM_REQ(N)) ifb ();
   sdram_req_arbiter #(.NUM_REQ(N), .TIMEOUT(TO), .REFRESH_INTERVAL(RI), .REFRESH_CYCLES(RC))
      dut_a (.clk(clk), .reset(rst), .bus(ifa));
   sdram_req_arbiter #(.NUM_REQ(N), .TIMEOUT(200), .REFRESH_INTERVAL(RI), .REFRESH_CYCLES(RC))
      dut_b (.clk(clk), .reset(rst), .bus(ifb));

   int n_asrt = 0, n_fail = 0, gcyc = 0;
   int m_t, m_own, m_age, m_rfr, m_ptr;
   bit m_pend, m_ovr, m_we, m_err;
   logic [N-1:0] m_done;
   int n_wr, n_rd, n_gc, n_done, n_err, n_rf, is_cyc, done_cyc, rf_cyc;
   int dcnt[N];
   logic [N-1:0] gq[$];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_asrt++;
      assert (act === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
      end
   endtask

   // model: m_own<0 means no owner, m_age counts cycles since the ISSUE cycle, m_rfr refresh cycles left
   task automatic model_edge();
      bit wrap, old_pend;
      if (rst) begin
         m_t = 0; m_own = -1; m_age = 0; m_rfr = 0; m_ptr = 0;
         m_pend = 0; m_ovr = 0; m_we = 0; m_err = 0; m_done = '0;
         return;
      end
      wrap = (m_t % RI) == RI - 1;
      old_pend = m_pend;
      m_t++;
      m_done = '0;
      m_err = 0;
      if (m_rfr > 0) m_rfr--;
      else if (m_own >= 0) begin
         if (m_age > 0 && (ifa.ctrl_data_valid || m_age == TO)) begin
            m_done = N'(1 << m_own);
            m_err = !ifa.ctrl_data_valid;
            m_ptr = (m_own + 1) % N;
            m_own = -1;
         end else m_age++;
      end else if (old_pend) begin
         m_rfr = RC;
         m_pend = 0;
      end else if (ifa.req != 0) begin
         for (int k = 0; k < N; k++)
            if (ifa.req[(m_ptr + k) % N]) begin
               m_own = (m_ptr + k) % N;
               break;
            end
         m_we = ifa.req_we[m_own];
         m_age = 0;
      end
      if (wrap) begin
         if (old_pend) m_ovr = 1;
         m_pend = 1;
      end
   endtask

   function automatic logic [12:0] exp_vec();
      logic [N-1:0] g = (m_own >= 0) ? N'(1 << m_own) : '0;
      bit iss = m_own >= 0 && m_age == 0;
      return {g, m_done, m_err, iss && !m_we, iss && m_we, m_rfr == RC, m_ovr};
   endfunction

   function automatic logic [12:0] act_vec();
      return {ifa.grant, ifa.done, ifa.err, ifa.ctrl_read_req, ifa.ctrl_write_req,
              ifa.ctrl_refresh_req, ifa.refresh_overrun};
   endfunction

   task automatic clr();
      n_wr = 0; n_rd = 0; n_gc = 0; n_done = 0; n_err = 0; n_rf = 0;
      is_cyc = 0; done_cyc = 0; rf_cyc = 0;
      foreach (dcnt[i]) dcnt[i] = 0;
      gq.delete();
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      gcyc++;
      chk($sformatf("cycle %0d outputs", gcyc), 32'(act_vec()), 32'(exp_vec()));
      if (ifa.ctrl_write_req) n_wr++;
      if (ifa.ctrl_read_req) n_rd++;
      if (|ifa.grant) n_gc++;
      if (ifa.ctrl_write_req || ifa.ctrl_read_req) begin
         gq.push_back(ifa.grant);
         is_cyc = gcyc;
      end
      if (|ifa.done) begin
         n_done++;
         done_cyc = gcyc;
         for (int i = 0; i < N; i++) if (ifa.done[i]) dcnt[i]++;
      end
      if (ifa.err) n_err++;
      if (ifa.ctrl_refresh_req) begin
         n_rf++;
         rf_cyc = gcyc;
      end
   endtask

   task automatic do_reset();
      rst = 1;
      ifa.req = '0; ifa.req_we = '0; ifa.ctrl_data_valid = 0;
      ifb.req = '0; ifb.req_we = '0; ifb.ctrl_data_valid = 0;
      step();
      step();
      rst = 0;
      clr();
   endtask

   // clients drop req in their done cycle unless hold; dv_at is the ISSUE-relative data_valid cycle
   task automatic run(input int cycles, input int dv_at, input bit hold, input bit rnd);
      logic [N-1:0] drop;
      for (int c = 0; c < cycles; c++) begin
         if (!hold) ifa.req = ifa.req & ~m_done;
         if (rnd) begin
            drop = ($urandom_range(0, 7) == 0 && m_own >= 0) ? N'(1 << m_own) : '0;
            ifa.req = (ifa.req & ~drop) | (N'($urandom) & N'($urandom));
            ifa.req_we = N'($urandom);
            ifa.ctrl_data_valid = $urandom_range(0, 7) == 0;
         end else ifa.ctrl_data_valid = dv_at >= 0 && m_own >= 0 && m_age == dv_at;
         step();
      end
      ifa.ctrl_data_valid = 0;
   endtask

   initial begin
      ifa.req = '0; ifa.req_we = '0; ifa.ctrl_data_valid = 0;
      ifb.req = '0; ifb.req_we = '0; ifb.ctrl_data_valid = 0;
      // single write
      do_reset();
      ifa.req = 4'b0001; ifa.req_we = 4'b0001;
      run(12, 5, 0, 0);
      chk("t1 write pulses", n_wr, 1);
      chk("t1 read pulses", n_rd, 0);
      chk("t1 grant cycles", n_gc, 6);
      chk("t1 done client0", dcnt[0], 1);
      chk("t1 err pulses", n_err, 0);
      // round-robin with all clients holding req
      do_reset();
      ifa.req = 4'b1111; ifa.req_we = 4'b0000;
      run(25, 3, 1, 0);
      chk("t2 grant count", gq.size(), 5);
      for (int i = 0; i < 5; i++)
         chk($sformatf("t2 grant %0d", i), 32'(i < gq.size() ? gq[i] : '0), 32'(1 << (i % N)));
      chk("t2 done client0", dcnt[0], 2);
      for (int i = 1; i < N; i++) chk($sformatf("t2 done client%0d", i), dcnt[i], 1);
      // timeout, then success, then data_valid on the timeout cycle
      do_reset();
      ifa.req = 4'b0100;
      run(22, -1, 0, 0);
      chk("t3 timeout err", n_err, 1);
      chk("t3 timeout latency", done_cyc - is_cyc, TO + 1);
      ifa.req = 4'b0100;
      run(10, 4, 0, 0);
      ifa.req = 4'b0100;
      run(22, TO, 0, 0);
      chk("t3 dones", dcnt[2], 3);
      chk("t3 err total", n_err, 1);
      // refresh pending appears as client 1 raises req
      do_reset();
      run(RI, -1, 0, 0);
      ifa.req = 4'b0010;
      run(14, 2, 0, 0);
      chk("t4 refresh pulses", n_rf, 1);
      chk("t4 refresh to issue", is_cyc - rf_cyc, RC + 1);
      chk("t4 grant", 32'(gq.size() > 0 ? gq[0] : '0), 32'(4'b0010));
      chk("t4 done client1", dcnt[1], 1);
      // overrun on the long-timeout instance
      do_reset();
      ifb.req = 4'b0001;
      for (int c = 0; c < 260; c++) begin
         step();
         chk($sformatf("t5 overrun t=%0d", m_t), 32'(ifb.refresh_overrun), 32'(m_t >= 2 * RI));
      end
      do_reset();
      chk("t5 overrun cleared", 32'(ifb.refresh_overrun), 0);
      // reset during WAIT
      ifa.req = 4'b0010;
      run(8, 3, 0, 0);
      ifa.req = 4'b0100;
      run(3, -1, 0, 0);
      clr();
      rst = 1;
      step();
      rst = 0;
      chk("t6 grant after reset", 32'(ifa.grant), 0);
      ifa.req = 4'b1111; ifa.req_we = 4'b0000;
      run(6, 2, 1, 0);
      chk("t6 first grant", 32'(gq.size() > 0 ? gq[0] : '0), 32'(4'b0001));
      chk("t6 aborted client done", dcnt[2], 0);
      chk("t6 err pulses", n_err, 0);
      // random traffic
      do_reset();
      run(400, -1, 0, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
